// File: rtl/rr_stream_mux.sv
// Registered N:1 stream multiplexer with round-robin arbitration and optional
// packet locking. One output register sits between the producers and the consumer.
module rr_stream_mux #(
  parameter int S    = 2,
  parameter int T    = 8,
  parameter int LOCK = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [(1<<S)*T-1:0]   d,
  input  logic [(1<<S)-1:0]     d_valid,
  input  logic [(1<<S)-1:0]     d_last,
  output logic [(1<<S)-1:0]     d_ready,
  output logic [T-1:0]          z,
  output logic                  z_valid,
  input  logic                  z_ready,
  output logic                  z_last,
  output logic [S-1:0]          z_sel
);

  localparam int N = 1 << S;

  logic [T-1:0] d_arr [N];

  logic [T-1:0] z_q, z_d;
  logic         z_valid_q, z_valid_d;
  logic         z_last_q, z_last_d;
  logic [S-1:0] z_sel_q, z_sel_d;
  logic [S-1:0] ptr_q, ptr_d;
  logic [S-1:0] lk_q, lk_d;
  logic         locked_q, locked_d;

  logic [S-1:0] g;
  logic         found;
  logic         free;
  logic         xfer;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign d_arr[gi]   = d[gi*T +: T];
      assign d_ready[gi] = xfer && (int'(g) == gi);
    end
  endgenerate

  // Rotating priority scan starting at ptr; a held lock restricts the scan
  // to the locked channel so other producers cannot slip in mid-packet.
  always_comb begin
    logic [S-1:0] idx;
    g     = ptr_q;
    found = 1'b0;
    idx   = '0;
    if (LOCK != 0 && locked_q) begin
      g     = lk_q;
      found = d_valid[lk_q];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = ptr_q + S'(k);
        if (!found && d_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
  end

  assign free = ~z_valid_q | z_ready;
  assign xfer = free & found & ~reset;

  always_comb begin
    z_d       = z_q;
    z_valid_d = z_valid_q;
    z_last_d  = z_last_q;
    z_sel_d   = z_sel_q;
    ptr_d     = ptr_q;
    lk_d      = lk_q;
    locked_d  = locked_q;
    if (xfer) begin
      z_d       = d_arr[g];
      z_last_d  = d_last[g];
      z_sel_d   = g;
      z_valid_d = 1'b1;
      if (LOCK == 0 || d_last[g]) begin
        ptr_d    = g + S'(1);
        locked_d = 1'b0;
      end else begin
        locked_d = 1'b1;
        lk_d     = g;
      end
    end else if (z_ready) begin
      // Drained with nothing to replace it; payload fields keep their last value.
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
      z_last_q  <= 1'b0;
      z_sel_q   <= '0;
      ptr_q     <= '0;
      lk_q      <= '0;
      locked_q  <= 1'b0;
    end else begin
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      z_last_q  <= z_last_d;
      z_sel_q   <= z_sel_d;
      ptr_q     <= ptr_d;
      lk_q      <= lk_d;
      locked_q  <= locked_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign z_last  = z_last_q;
  assign z_sel   = z_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: one unlocked and one locking instance share
// the same stimulus; each scenario checks the instance it targets.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d;
  logic [3:0]  d_valid;
  logic [3:0]  d_last;
  logic        z_ready;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  z0, z1;
  logic        zv0, zv1, zl0, zl1;
  logic [1:0]  zs0, zs1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.S(2), .T(8), .LOCK(0)) dut_rr (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(rdy0), .z(z0), .z_valid(zv0), .z_ready(z_ready),
    .z_last(zl0), .z_sel(zs0)
  );

  rr_stream_mux #(.S(2), .T(8), .LOCK(1)) dut_lk (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_last(d_last),
    .d_ready(rdy1), .z(z1), .z_valid(zv1), .z_ready(z_ready),
    .z_last(zl1), .z_sel(zs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("chk %-16s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  logic [1:0] rr_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rr_z   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [1:0] sw_sel [4] = '{2'd0, 2'd3, 2'd0, 2'd3};

  initial begin
    reset   = 1'b1;
    d       = {8'h44, 8'h33, 8'h22, 8'h11};
    d_valid = 4'b1111;
    d_last  = 4'b0000;
    z_ready = 1'b1;

    // Reset state with every channel requesting.
    tick();
    tick();
    chk("rst_rdy0", 32'(rdy0), 32'h0);
    chk("rst_rdy1", 32'(rdy1), 32'h0);
    chk("rst_zv", 32'(zv0), 32'h0);
    chk("rst_z", 32'(z0), 32'h0);
    chk("rst_zsel", 32'(zs0), 32'h0);
    chk("rst_zv_lk", 32'(zv1), 32'h0);

    // Round robin over all four channels.
    reset = 1'b0;
    #1;
    chk("rr_rdy_first", 32'(rdy0), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_sel%0d", k), 32'(zs0), 32'(rr_sel[k]));
      chk($sformatf("rr_z%0d", k), 32'(z0), 32'(rr_z[k]));
      chk($sformatf("rr_zv%0d", k), 32'(zv0), 32'h1);
    end

    // Skip idle channels and wrap from 3 back to 0.
    hold_reset();
    d_valid = 4'b1001;
    reset   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("sw_sel%0d", k), 32'(zs0), 32'(sw_sel[k]));
    end
    d_valid = 4'b0100;
    #1;
    chk("sw_rdy2", 32'(rdy0), 32'b0100);
    tick();
    chk("sw_sel_ch2", 32'(zs0), 32'h2);
    chk("sw_z_ch2", 32'(z0), 32'h33);

    // Backpressure: three stalled cycles, then resume with channel 1.
    hold_reset();
    d_valid = 4'b1111;
    reset   = 1'b0;
    tick();
    chk("bp_first_z", 32'(z0), 32'h11);
    z_ready = 1'b0;
    #1;
    chk("bp_rdy_stall", 32'(rdy0), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_z%0d", k), 32'(z0), 32'h11);
      chk($sformatf("bp_sel%0d", k), 32'(zs0), 32'h0);
      chk($sformatf("bp_zv%0d", k), 32'(zv0), 32'h1);
      chk($sformatf("bp_rdy%0d", k), 32'(rdy0), 32'h0);
    end
    z_ready = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(rdy0), 32'b0010);
    tick();
    chk("bp_next_sel", 32'(zs0), 32'h1);
    chk("bp_next_z", 32'(z0), 32'h22);
    tick();
    chk("bp_after_z", 32'(z0), 32'h33);

    // Packet lock: channel 1 sends three beats while channel 2 waits.
    hold_reset();
    d_valid = 4'b0110;
    d_last  = 4'b0000;
    d       = {8'h44, 8'h33, 8'hA1, 8'h11};
    reset   = 1'b0;
    tick();
    chk("lk_b1_sel", 32'(zs1), 32'h1);
    chk("lk_b1_z", 32'(z1), 32'hA1);
    d[15:8] = 8'hA2;
    #1;
    chk("lk_rdy_hold", 32'(rdy1), 32'b0010);
    tick();
    chk("lk_b2_sel", 32'(zs1), 32'h1);
    chk("lk_b2_z", 32'(z1), 32'hA2);
    d[15:8] = 8'hA3;
    d_last  = 4'b0010;
    tick();
    chk("lk_b3_sel", 32'(zs1), 32'h1);
    chk("lk_b3_last", 32'(zl1), 32'h1);
    chk("lk_b3_z", 32'(z1), 32'hA3);
    d_last = 4'b0000;
    tick();
    chk("lk_next_sel", 32'(zs1), 32'h2);
    chk("lk_next_z", 32'(z1), 32'h33);

    // Locked producer goes idle mid-packet: nobody else may be granted.
    hold_reset();
    d_valid = 4'b0110;
    d_last  = 4'b0000;
    reset   = 1'b0;
    tick();
    chk("gap_b1_sel", 32'(zs1), 32'h1);
    d_valid = 4'b0100;
    #1;
    chk("gap_rdy", 32'(rdy1), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("gap_zv%0d", k), 32'(zv1), 32'h0);
      chk($sformatf("gap_rdy%0d", k), 32'(rdy1), 32'h0);
    end
    d_valid = 4'b0110;
    d_last  = 4'b0010;
    tick();
    chk("gap_resume_sel", 32'(zs1), 32'h1);
    chk("gap_resume_last", 32'(zl1), 32'h1);
    d_last = 4'b0000;

    // Reset in the middle of a channel 3 packet.
    hold_reset();
    d       = {8'h44, 8'h33, 8'h22, 8'h11};
    d_valid = 4'b1000;
    reset   = 1'b0;
    tick();
    tick();
    chk("mr_b2_sel", 32'(zs1), 32'h3);
    reset   = 1'b1;
    d_valid = 4'b1111;
    #1;
    chk("mr_rdy_in_rst", 32'(rdy1), 32'h0);
    tick();
    chk("mr_zv_cleared", 32'(zv1), 32'h0);
    reset = 1'b0;
    #1;
    chk("mr_rdy_after", 32'(rdy1), 32'b0001);
    tick();
    chk("mr_first_sel", 32'(zs1), 32'h0);
    chk("mr_first_z", 32'(z1), 32'h11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
